// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALU operation codes, mux selects and the bundled control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_EXCEPT    = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_ANDI = 6'd12;
    localparam logic [5:0] OP_ORI  = 6'd13;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IOP   = 2'b11;

    // ALU B-operand selects: register, constant 4, immediate, immediate << 2
    localparam logic [1:0] B_REG   = 2'b00;
    localparam logic [1:0] B_FOUR  = 2'b01;
    localparam logic [1:0] B_IMM   = 2'b10;
    localparam logic [1:0] B_SHIMM = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_EXC    = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem2reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic       exception;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle. master = controller, slave = datapath.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic       exception;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               mem2reg, ir_write, reg_write, reg_dst, alu_src_a, exception,
               alu_src_b, pc_source, alu_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
               mem2reg, ir_write, reg_write, reg_dst, alu_src_a, exception,
               alu_src_b, pc_source, alu_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with a memory-wait watchdog that traps to EXCEPT.
// Outputs are decoded combinationally from state, latched opcode and mem_ready.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    localparam int            WW      = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

    state_e        state_q;
    logic [WW-1:0] wait_q;
    logic [5:0]    opc_q;
    logic          timeout;
    ctrl_t         ctrl;

    // The cycle that would make the count reach TIMEOUT is the last one tolerated.
    assign timeout = !bus.mem_ready && (wait_q == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            opc_q   <= '0;
        end else begin
            wait_q <= '0;
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready)  state_q <= S_DECODE;
                    else if (timeout)   state_q <= S_EXCEPT;
                    else                wait_q  <= wait_q + WW'(1);
                end
                S_DECODE: begin
                    opc_q <= bus.opcode;
                    case (bus.opcode)
                        OP_R:                             state_q <= S_R_EXEC;
                        OP_LW, OP_SW:                     state_q <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE:                   state_q <= S_BRANCH;
                        OP_J:                             state_q <= S_JUMP;
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_q <= S_I_EXEC;
                        default:                          state_q <= S_EXCEPT;
                    endcase
                end
                S_MEM_ADDR: state_q <= (opc_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ: begin
                    if (bus.mem_ready)  state_q <= S_MEM_WB;
                    else if (timeout)   state_q <= S_EXCEPT;
                    else                wait_q  <= wait_q + WW'(1);
                end
                S_MEM_WRITE: begin
                    if (bus.mem_ready)  state_q <= S_FETCH;
                    else if (timeout)   state_q <= S_EXCEPT;
                    else                wait_q  <= wait_q + WW'(1);
                end
                S_R_EXEC: state_q <= S_R_WB;
                S_I_EXEC: state_q <= S_I_WB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = B_FOUR;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            S_DECODE:   ctrl.alu_src_b = B_SHIMM;
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = B_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem2reg   = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = B_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = B_IMM;
                ctrl.alu_op    = ALU_IOP;
            end
            S_I_WB:     ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = B_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_BRANCH;
                ctrl.branch_ne     = (opc_q == OP_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            S_EXCEPT: begin
                ctrl.exception = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_EXC;
            end
            default: ;
        endcase
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.branch_ne     = ctrl.branch_ne;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.mem2reg       = ctrl.mem2reg;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.exception     = ctrl.exception;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction state/output walks,
// latched-opcode use, the FETCH watchdog and asynchronous reset.
module tb_multicycle_control;

    // Output word: {pw,pwc,bne,iod, mr,mw,m2r,irw, rw,rdst,asa,exc, asb, pcs, aop}
    localparam logic [17:0] E_FETCH_W = {12'b0000_1000_0000, 2'b01, 2'b00, 2'b00};
    localparam logic [17:0] E_FETCH_R = {12'b1000_1001_0000, 2'b01, 2'b00, 2'b00};
    localparam logic [17:0] E_DECODE  = {12'b0000_0000_0000, 2'b11, 2'b00, 2'b00};
    localparam logic [17:0] E_MADDR   = {12'b0000_0000_0010, 2'b10, 2'b00, 2'b00};
    localparam logic [17:0] E_MREAD   = {12'b0001_1000_0000, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] E_MWB     = {12'b0000_0010_1000, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] E_MWRITE  = {12'b0001_0100_0000, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] E_REXEC   = {12'b0000_0000_0010, 2'b00, 2'b00, 2'b10};
    localparam logic [17:0] E_RWB     = {12'b0000_0000_1100, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] E_IEXEC   = {12'b0000_0000_0010, 2'b10, 2'b00, 2'b11};
    localparam logic [17:0] E_IWB     = {12'b0000_0000_1000, 2'b00, 2'b00, 2'b00};
    localparam logic [17:0] E_BEQ     = {12'b0100_0000_0010, 2'b00, 2'b01, 2'b01};
    localparam logic [17:0] E_BNE     = {12'b0110_0000_0010, 2'b00, 2'b01, 2'b01};
    localparam logic [17:0] E_JUMP    = {12'b1000_0000_0000, 2'b00, 2'b10, 2'b00};
    localparam logic [17:0] E_EXCEPT  = {12'b1000_0000_0001, 2'b00, 2'b11, 2'b00};

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    multicycle_control_if bus ();

    multicycle_control #(.TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [17:0] outs;
    assign outs = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d,
                   bus.mem_read, bus.mem_write, bus.mem2reg, bus.ir_write,
                   bus.reg_write, bus.reg_dst, bus.alu_src_a, bus.exception,
                   bus.alu_src_b, bus.pc_source, bus.alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        bus.opcode = 6'd0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd0 || outs !== E_FETCH_W) begin
            errors++;
            $display("FAIL reset_held: state=%0d outs=%b, expected state=0 outs=%b", bus.state, outs, E_FETCH_W);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd0 || outs !== E_FETCH_W) begin
            errors++;
            $display("FAIL reset_release: state=%0d outs=%b, expected state=0 outs=%b", bus.state, outs, E_FETCH_W);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [17:0] eo [4] = '{E_FETCH_R, E_DECODE, E_REXEC, E_RWB};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.opcode = 6'd0;
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (bus.state !== es[i] || outs !== eo[i]) begin
                errors++;
                $display("FAIL rtype step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, bus.state, outs, es[i], eo[i]);
            end
        end
    endtask

    // Live opcode switches to sw after DECODE; the latched lw must still steer MEM_ADDR.
    task automatic test_lw_wait();
        logic [5:0]  op [8] = '{6'd35, 6'd35, 6'd43, 6'd43, 6'd43, 6'd43, 6'd43, 6'd43};
        logic        rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  es [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [17:0] eo [8] = '{E_FETCH_R, E_DECODE, E_MADDR, E_MREAD, E_MREAD, E_MREAD, E_MREAD, E_MWB};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.opcode = op[i];
            bus.mem_ready = rd[i];
            #1;
            checks++;
            if (bus.state !== es[i] || outs !== eo[i]) begin
                errors++;
                $display("FAIL lw step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, bus.state, outs, es[i], eo[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [5:0]  op [4] = '{6'd43, 6'd43, 6'd35, 6'd35};
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        logic [17:0] eo [4] = '{E_FETCH_R, E_DECODE, E_MADDR, E_MWRITE};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.opcode = op[i];
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (bus.state !== es[i] || outs !== eo[i]) begin
                errors++;
                $display("FAIL sw step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, bus.state, outs, es[i], eo[i]);
            end
        end
    endtask

    task automatic test_itype();
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd10, 4'd11};
        logic [17:0] eo [4] = '{E_FETCH_R, E_DECODE, E_IEXEC, E_IWB};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.opcode = 6'd13;
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (bus.state !== es[i] || outs !== eo[i]) begin
                errors++;
                $display("FAIL itype step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, bus.state, outs, es[i], eo[i]);
            end
        end
    endtask

    // bne then beq; the live opcode in BRANCH is swapped so branch_ne must come from the latch.
    task automatic test_branch();
        logic [5:0]  op [6] = '{6'd5, 6'd5, 6'd0, 6'd4, 6'd4, 6'd5};
        logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8};
        logic [17:0] eo [6] = '{E_FETCH_R, E_DECODE, E_BNE, E_FETCH_R, E_DECODE, E_BEQ};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.opcode = op[i];
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (bus.state !== es[i] || outs !== eo[i]) begin
                errors++;
                $display("FAIL branch step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, bus.state, outs, es[i], eo[i]);
            end
        end
    endtask

    task automatic test_jump_except();
        logic [5:0]  op [6] = '{6'd2, 6'd2, 6'd2, 6'd63, 6'd63, 6'd63};
        logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd12};
        logic [17:0] eo [6] = '{E_FETCH_R, E_DECODE, E_JUMP, E_FETCH_R, E_DECODE, E_EXCEPT};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.opcode = op[i];
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (bus.state !== es[i] || outs !== eo[i]) begin
                errors++;
                $display("FAIL jump_except step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, bus.state, outs, es[i], eo[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bus.opcode = 6'd2;
        // Fifteen starved FETCH cycles, then the trap.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (bus.state !== 4'd0 || outs !== E_FETCH_W) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d: state=%0d outs=%b, expected state=0 outs=%b", i + 1, bus.state, outs, E_FETCH_W);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd12 || outs !== E_EXCEPT) begin
            errors++;
            $display("FAIL timeout_trap: state=%0d outs=%b, expected state=12 outs=%b", bus.state, outs, E_EXCEPT);
        end
        // Fourteen starved cycles, ready on the fifteenth: normal fetch wins.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (bus.state !== 4'd0 || outs !== E_FETCH_W) begin
                errors++;
                $display("FAIL timeout_rewait cycle %0d: state=%0d outs=%b, expected state=0 outs=%b", i + 1, bus.state, outs, E_FETCH_W);
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.state !== 4'd0 || outs !== E_FETCH_R) begin
            errors++;
            $display("FAIL timeout_late_ready: state=%0d outs=%b, expected state=0 outs=%b", bus.state, outs, E_FETCH_R);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd1 || outs !== E_DECODE) begin
            errors++;
            $display("FAIL timeout_decode: state=%0d outs=%b, expected state=1 outs=%b", bus.state, outs, E_DECODE);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd9 || outs !== E_JUMP) begin
            errors++;
            $display("FAIL timeout_jump: state=%0d outs=%b, expected state=9 outs=%b", bus.state, outs, E_JUMP);
        end
    endtask

    task automatic test_reset_mid_sw();
        logic        rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        logic [17:0] eo [4] = '{E_FETCH_R, E_DECODE, E_MADDR, E_MWRITE};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.opcode = 6'd43;
            bus.mem_ready = rd[i];
            #1;
            checks++;
            if (bus.state !== es[i] || outs !== eo[i]) begin
                errors++;
                $display("FAIL rst_sw step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, bus.state, outs, es[i], eo[i]);
            end
        end
        // Asynchronous: asserted and checked between clock edges.
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.mem_write !== 1'b0 || outs !== E_FETCH_W) begin
            errors++;
            $display("FAIL rst_async: state=%0d mem_write=%b outs=%b, expected state=0 mem_write=0 outs=%b", bus.state, bus.mem_write, outs, E_FETCH_W);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (bus.state !== 4'd0 || bus.mem_write !== 1'b0 || bus.reg_write !== 1'b0) begin
                errors++;
                $display("FAIL rst_after cycle %0d: state=%0d mem_write=%b reg_write=%b, expected state=0 mem_write=0 reg_write=0", i, bus.state, bus.mem_write, bus.reg_write);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.opcode = 6'd0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_itype();
        test_branch();
        test_jump_except();
        test_timeout();
        test_reset_mid_sw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
